fetch_buffer: RTL and testbench

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/lite16_pkg.sv | 13 +
 rtl/fetch_buffer_if.sv | 33 +++
 rtl/fetch_buffer_mem.sv | 32 +++
 rtl/fetch_buffer.sv | 83 ++++++++
 tb/tb_fetch_buffer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/lite16_pkg.sv
// Shared constants for the lite16 front end: datapath word width, fetch
// buffer depth, and the occupancy-counter width helper.
package lite16_pkg;

  localparam int WORD_W   = 16;
  localparam int FB_DEPTH = 4;

  // An occupancy counter must represent 0..depth inclusive, hence the extra bit.
  function automatic int fb_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch-to-decode handshake bundle. The master side is the fetch stage plus
// the decode consumer; the slave side is the buffer itself.
interface fetch_buffer_if
  import lite16_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = FB_DEPTH
);

  localparam int CNT_W = fb_cnt_w(DEPTH);

  logic             in_valid;
  logic [WIDTH-1:0] in_instr;
  logic [WIDTH-1:0] in_pc;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_instr;
  logic [WIDTH-1:0] out_pc;
  logic             out_ready;
  logic             flush;
  logic [CNT_W-1:0] count;

  modport master (
    output in_valid, in_instr, in_pc, out_ready, flush,
    input  in_ready, out_valid, out_instr, out_pc, count
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready, flush,
    output in_ready, out_valid, out_instr, out_pc, count
  );

endinterface

// File: rtl/fetch_buffer_mem.sv
// Entry storage for the fetch buffer: DEPTH words of {pc, instr}, one write
// port, one combinational read port, asynchronously cleared.
module fetch_mem
  import lite16_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = FB_DEPTH
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [2*WIDTH-1:0]       i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [2*WIDTH-1:0]       o_rdata
);

  logic [2*WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_buffer.sv
// Fetch buffer between the PC/ROM stage and decode: a DEPTH-entry FIFO with
// registered-only output (one-cycle fetch-to-decode latency) and jump flush.
module fetch_buffer
  import lite16_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = FB_DEPTH
) (
  input  logic           clk,
  input  logic           rst,
  fetch_buffer_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = fb_cnt_w(DEPTH);

  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_push;
  logic               w_pop;
  logic               w_mem_we;
  logic [2*WIDTH-1:0] w_wr_data;
  logic [2*WIDTH-1:0] w_rd_data;

  // Handshake flags depend only on registered occupancy: no pass-through
  // when full and no bypass when empty.
  assign w_in_ready  = (r_count < CNT_W'(DEPTH));
  assign w_out_valid = (r_count != '0);
  assign w_push      = bus.in_valid  & w_in_ready;
  assign w_pop       = bus.out_ready & w_out_valid;

  // A flush cancels any concurrent push, so storage must not be written either.
  assign w_mem_we    = w_push & ~bus.flush;
  assign w_wr_data   = {bus.in_pc, bus.in_instr};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  fetch_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_we    (w_mem_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wr_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_instr = w_out_valid ? w_rd_data[WIDTH-1:0]       : '0;
  assign bus.out_pc    = w_out_valid ? w_rd_data[2*WIDTH-1:WIDTH] : '0;
  assign bus.count     = r_count;

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed scenarios with literal
// expectations plus a queue model compared on every falling clock edge.
module tb_fetch_buffer;

  localparam int W = 16;
  localparam int D = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  bit   chk_en;

  fetch_buffer_if #(.WIDTH(W), .DEPTH(D)) bus ();

  fetch_buffer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain queue of {pc, instr}
  logic [31:0] q[$];
  bit          m_push;
  bit          m_pop;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
    end else if (bus.flush) begin
      q.delete();
    end else begin
      m_push = bus.in_valid && (q.size() < D);
      m_pop  = bus.out_ready && (q.size() != 0);
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back({bus.in_pc, bus.in_instr});
    end
  end

  always @(negedge clk) begin
    int n;
    if (chk_en) begin
      n = q.size();
      check("model_count", 32'(bus.count), 32'(n));
      check("model_out_valid", 32'(bus.out_valid), 32'(n != 0));
      check("model_in_ready", 32'(bus.in_ready), 32'(n < D));
      check("model_out_instr", 32'(bus.out_instr), (n != 0) ? 32'(q[0][15:0]) : 32'h0);
      check("model_out_pc", 32'(bus.out_pc), (n != 0) ? 32'(q[0][31:16]) : 32'h0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] ins, input logic [15:0] pc);
    bus.in_valid = 1'b1;
    bus.in_instr = ins;
    bus.in_pc    = pc;
    cyc();
    bus.in_valid = 1'b0;
  endtask

  task automatic head(input string name, input logic [15:0] ins, input logic [15:0] pc);
    check({name, "_valid"}, 32'(bus.out_valid), 32'h1);
    check({name, "_instr"}, 32'(bus.out_instr), 32'(ins));
    check({name, "_pc"}, 32'(bus.out_pc), 32'(pc));
  endtask

  initial begin
    logic [15:0] exp35 [6];
    logic [15:0] seq;
    checks = 0;
    errors = 0;
    chk_en = 1'b0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'h1);
    check("rst_count", 32'(bus.count), 32'h0);
    check("rst_out_instr", 32'(bus.out_instr), 32'h0);
    check("rst_out_pc", 32'(bus.out_pc), 32'h0);
    chk_en = 1'b1;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    check("post_rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'h1);

    // First push appears one cycle later
    push(16'h1234, 16'h0000);
    head("first", 16'h1234, 16'h0000);
    check("first_count", 32'(bus.count), 32'h1);
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    check("first_pop_count", 32'(bus.count), 32'h0);

    // Fill, overflow attempt, drain in order
    for (int i = 1; i <= 4; i++) push(16'hA000 + 16'(i), 16'(i * 2));
    check("full_count", 32'(bus.count), 32'h4);
    check("full_in_ready", 32'(bus.in_ready), 32'h0);
    push(16'hBEEF, 16'h0100);
    check("ovf_count", 32'(bus.count), 32'h4);
    head("ovf_head", 16'hA001, 16'h0002);
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      head($sformatf("drain%0d", i), 16'hA000 + 16'(i), 16'(i * 2));
      cyc();
    end
    bus.out_ready = 1'b0;
    check("drain_count", 32'(bus.count), 32'h0);
    check("drain_out_valid", 32'(bus.out_valid), 32'h0);

    // At full only the pop happens; then steady push+pop at count 2
    for (int i = 1; i <= 4; i++) push(16'hC000 + 16'(i), 16'h0010 + 16'(i));
    bus.in_valid  = 1'b1;
    bus.in_instr  = 16'hD001;
    bus.in_pc     = 16'h0030;
    bus.out_ready = 1'b1;
    cyc();
    check("fullpp_count", 32'(bus.count), 32'h3);
    check("fullpp_in_ready", 32'(bus.in_ready), 32'h1);
    head("fullpp_head", 16'hC002, 16'h0012);
    bus.in_valid = 1'b0;
    cyc();
    check("two_count", 32'(bus.count), 32'h2);
    exp35[0] = 16'hC003;
    exp35[1] = 16'hC004;
    exp35[2] = 16'hE001;
    exp35[3] = 16'hE002;
    exp35[4] = 16'hE003;
    exp35[5] = 16'hE004;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("pp%0d_head", i), 32'(bus.out_instr), 32'(exp35[i]));
      check($sformatf("pp%0d_count", i), 32'(bus.count), 32'h2);
      bus.in_valid = 1'b1;
      bus.in_instr = 16'hE001 + 16'(i);
      bus.in_pc    = 16'h0040 + 16'(i);
      cyc();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("pp_end_count", 32'(bus.count), 32'h2);
    head("pp_end_head", 16'hE005, 16'h0044);
    bus.out_ready = 1'b1;
    cyc();
    cyc();
    bus.out_ready = 1'b0;
    check("pp_drain_count", 32'(bus.count), 32'h0);

    // Flush beats concurrent push and pop
    for (int i = 1; i <= 3; i++) push(16'hF000 + 16'(i), 16'h0050 + 16'(i));
    check("pre_flush_count", 32'(bus.count), 32'h3);
    bus.flush     = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 16'hF004;
    bus.in_pc     = 16'h0054;
    bus.out_ready = 1'b1;
    cyc();
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("flush_count", 32'(bus.count), 32'h0);
    check("flush_out_valid", 32'(bus.out_valid), 32'h0);
    check("flush_out_instr", 32'(bus.out_instr), 32'h0);
    cyc();
    check("flush_after_valid", 32'(bus.out_valid), 32'h0);
    push(16'hF005, 16'h0060);
    head("post_flush_head", 16'hF005, 16'h0060);
    check("post_flush_count", 32'(bus.count), 32'h1);
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;

    // Asynchronous reset between edges
    push(16'h1111, 16'h0020);
    push(16'h2222, 16'h0022);
    check("pre_arst_count", 32'(bus.count), 32'h2);
    #2 rst = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'h0);
    check("arst_count", 32'(bus.count), 32'h0);
    check("arst_out_instr", 32'(bus.out_instr), 32'h0);
    check("arst_in_ready", 32'(bus.in_ready), 32'h1);
    cyc();
    rst = 1'b1;
    push(16'h3333, 16'h0040);
    head("post_arst_head", 16'h3333, 16'h0040);
    check("post_arst_count", 32'(bus.count), 32'h1);
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;

    // Random traffic against the queue model
    seq = 16'h0100;
    for (int n = 0; n < 10000; n++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_instr  = seq;
      bus.in_pc     = seq ^ 16'h5A5A;
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.flush     = ($urandom_range(0, 63) == 0);
      seq = seq + 16'h1;
      cyc();
    end
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 6; n++) cyc();
    check("final_count", 32'(bus.count), 32'h0);
    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
